// File: rtl/alu_legv8_pkg.sv
// Shared definitions for the LEGv8 ALU and the blocks that borrow it.
// Function-select codes, status-flag positions and the multiplier sequencer states.
package alu_legv8_pkg;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  localparam int unsigned ST_Z = 0;
  localparam int unsigned ST_N = 1;
  localparam int unsigned ST_C = 2;
  localparam int unsigned ST_V = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier (low WIDTH product bits) that borrows the
// external LEGv8 ALU for every add and shift, one ALU operation per clock.
module alu_mul_sequencer
  import alu_legv8_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [4:0]       alu_FS,
  output logic             alu_C0,
  input  logic [WIDTH-1:0] alu_F,
  input  logic [3:0]       alu_status
);

  mul_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic             ovf_pend;
  logic             status_unused;

  assign status_unused = ^{alu_status[ST_V], alu_status[ST_N]};
  assign alu_C0        = 1'b0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand    <= a_in;
            mplier   <= b_in;
            acc      <= '0;
            ovf      <= 1'b0;
            ovf_pend <= 1'b0;
            busy     <= 1'b1;
            if (b_in == '0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              product  <= '0;
              overflow <= 1'b0;
            end else if (b_in[0]) begin
              state <= S_ADD;
            end else begin
              state <= S_SHL;
            end
          end
        end
        S_ADD: begin
          acc <= alu_F;
          if (alu_status[ST_C]) ovf <= 1'b1;
          state <= S_SHL;
        end
        S_SHL: begin
          mcand    <= alu_F;
          ovf_pend <= mcand[WIDTH-1];
          state    <= S_SHR;
        end
        S_SHR: begin
          mplier <= alu_F;
          if (alu_status[ST_Z]) begin
            // done/product are registered on entry so they are visible during DONE
            state    <= S_DONE;
            done     <= 1'b1;
            product  <= acc;
            overflow <= ovf;
          end else begin
            // a bit lost by the last shift only matters if multiplier bits remain
            if (ovf_pend) ovf <= 1'b1;
            state <= alu_F[0] ? S_ADD : S_SHL;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    alu_A  = '0;
    alu_B  = '0;
    alu_FS = FS_AND;
    case (state)
      S_ADD: begin
        alu_A  = acc;
        alu_B  = mcand;
        alu_FS = FS_ADD;
      end
      S_SHL: begin
        alu_A  = mcand;
        alu_B  = WIDTH'(1);
        alu_FS = FS_LSL;
      end
      S_SHR: begin
        alu_A  = mplier;
        alu_B  = WIDTH'(1);
        alu_FS = FS_LSR;
      end
      default: begin
        alu_A  = '0;
        alu_B  = '0;
        alu_FS = FS_AND;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer with a behavioural LEGv8 ALU attached to its alu_* ports.
module tb_alu_mul_sequencer;
  import alu_legv8_pkg::*;

  localparam int unsigned W = 64;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, overflow, alu_C0;
  logic [W-1:0] product, alu_A, alu_B, alu_F;
  logic [4:0]   alu_FS;
  logic [3:0]   alu_status;
  logic [W:0]   add_sum;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clock = ~clock;

  alu_mul_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product), .overflow(overflow),
    .alu_A(alu_A), .alu_B(alu_B), .alu_FS(alu_FS), .alu_C0(alu_C0),
    .alu_F(alu_F), .alu_status(alu_status)
  );

  always_comb begin
    add_sum = {1'b0, alu_A} + {1'b0, alu_B} + {{W{1'b0}}, alu_C0};
    case (alu_FS)
      FS_AND:  alu_F = alu_A & alu_B;
      FS_OR:   alu_F = alu_A | alu_B;
      FS_ADD:  alu_F = add_sum[W-1:0];
      FS_XOR:  alu_F = alu_A ^ alu_B;
      FS_LSL:  alu_F = alu_A << alu_B[5:0];
      FS_LSR:  alu_F = alu_A >> alu_B[5:0];
      default: alu_F = '0;
    endcase
    alu_status       = '0;
    alu_status[ST_Z] = (alu_F == '0);
    alu_status[ST_N] = alu_F[W-1];
    alu_status[ST_C] = (alu_FS == FS_ADD) && add_sum[W];
    alu_status[ST_V] = (alu_FS == FS_ADD) && (alu_A[W-1] == alu_B[W-1]) && (alu_F[W-1] != alu_A[W-1]);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                output int unsigned lat);
    @(negedge clock);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] prod;
    logic         ovf;
    int unsigned  lat;
  } vec_t;

  localparam int unsigned NV = 10;
  vec_t vecs[NV];

  initial begin
    int unsigned lat;
    int unsigned extra;
    int unsigned ndone;
    int unsigned first_d;
    int unsigned second_d;
    logic        c0_seen;
    logic [4:0]  seq [8];

    vecs[0] = '{64'd3, 64'd5, 64'd15, 1'b0, 9};
    vecs[1] = '{64'h1234, 64'd0, 64'd0, 1'b0, 1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1, 6};
    vecs[3] = '{'1, '1, 64'd1, 1'b1, 193};
    vecs[4] = '{64'd7, 64'd9, 64'd63, 1'b0, 11};
    vecs[5] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 97};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 4};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'd3, 64'h8000_0000_0000_0000, 1'b1, 7};
    vecs[8] = '{64'h6000_0000_0000_0000, 64'd3, 64'h2000_0000_0000_0000, 1'b1, 7};
    vecs[9] = '{'1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 7};

    seq = '{FS_ADD, FS_LSL, FS_LSR, FS_LSL, FS_LSR, FS_ADD, FS_LSL, FS_LSR};

    // Reset state
    #12;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_product", product, '0);
    chk("rst_overflow", W'(overflow), '0);
    chk("rst_alu_A", alu_A, '0);
    chk("rst_alu_B", alu_B, '0);
    chk("rst_alu_FS", W'(alu_FS), '0);
    chk("rst_alu_C0", W'(alu_C0), '0);
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven products
    for (int i = 0; i < NV; i++) begin
      issue_and_wait(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), W'(lat), W'(vecs[i].lat));
      chk($sformatf("v%0d_product", i), product, vecs[i].prod);
      chk($sformatf("v%0d_overflow", i), W'(overflow), W'(vecs[i].ovf));
      chk($sformatf("v%0d_busy_at_done", i), W'(busy), W'(1));
      chk($sformatf("v%0d_fs_at_done", i), W'(alu_FS), W'(FS_AND));
      @(posedge clock); #1;
      chk($sformatf("v%0d_done_pulse", i), W'(done), '0);
      chk($sformatf("v%0d_idle_busy", i), W'(busy), '0);
      chk($sformatf("v%0d_product_held", i), product, vecs[i].prod);
    end

    // ALU operation sequence for 3*5
    @(negedge clock);
    a_in = 64'd3; b_in = 64'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("seq_fs%0d", i), W'(alu_FS), W'(seq[i]));
      @(posedge clock); #1;
    end
    chk("seq_done", W'(done), W'(1));
    chk("seq_product", product, 64'd15);
    @(posedge clock); #1;

    // A second start 10 cycles into 7*9 is dropped
    @(negedge clock);
    a_in = 64'd7; b_in = 64'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      if (lat == 10) begin
        @(negedge clock);
        a_in = 64'd1; b_in = 64'd1; start = 1'b1;
      end
      @(posedge clock); #1;
      start = 1'b0;
      lat++;
    end
    chk("ign_latency", W'(lat), W'(11));
    chk("ign_product", product, 64'd63);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (done) extra++;
    end
    chk("ign_no_second_done", W'(extra), '0);
    chk("ign_product_kept", product, 64'd63);

    // Asynchronous reset in the middle of a long operation
    @(negedge clock);
    a_in = '1; b_in = '1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", W'(busy), '0);
    chk("arst_done", W'(done), '0);
    chk("arst_product", product, '0);
    chk("arst_overflow", W'(overflow), '0);
    chk("arst_alu_A", alu_A, '0);
    chk("arst_alu_B", alu_B, '0);
    chk("arst_alu_FS", W'(alu_FS), '0);
    @(negedge clock);
    reset_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (done || busy) extra++;
    end
    chk("arst_stays_idle", W'(extra), '0);

    // start held high: back-to-back 2*3 operations
    ndone = 0; first_d = 0; second_d = 0; c0_seen = 1'b0;
    @(negedge clock);
    a_in = 64'd2; b_in = 64'd3; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (alu_C0) c0_seen = 1'b1;
      if (done) begin
        ndone++;
        if (ndone == 1) first_d = i;
        else if (ndone == 2) second_d = i;
        chk($sformatf("held_product%0d", ndone), product, 64'd6);
      end
    end
    start = 1'b0;
    chk("held_done_count", W'(ndone), W'(2));
    chk("held_first_latency", W'(first_d), W'(7));
    chk("held_spacing", W'(second_d - first_d), W'(8));
    chk("held_c0_zero", W'(c0_seen), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
